// File: rtl/bus_master_serializer_if.sv
// Request/bus signal bundle for the serial bus master.
// master modport is the serializer's view; slave is the requester/arbiter/decoder side.
interface bus_master_serializer_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        bus_req;
  logic        bus_grant;
  logic        bus_data_out;
  logic        bus_data_out_valid;
  logic        bus_mode;
  logic        busy;
  logic        done;

  modport master (
    input  req_valid, req_addr, req_wdata, bus_grant,
    output req_ready, bus_req, bus_data_out, bus_data_out_valid,
           bus_mode, busy, done
  );

  modport slave (
    output req_valid, req_addr, req_wdata, bus_grant,
    input  req_ready, bus_req, bus_data_out, bus_data_out_valid,
           bus_mode, busy, done
  );
endinterface

// File: rtl/bus_master_serializer.sv
// Serializes one 16-bit address then 8-bit write data, LSB first, onto a granted 1-bit bus.
// Frame: 1 REQ cycle, 16 addr + 8 data bit cycles (stretched by grant loss), 1 DONE cycle.
module bus_master_serializer (
  input  logic                           clk,
  input  logic                           rst_n,
  bus_master_serializer_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] addr_sr;
  logic [7:0]  data_sr;
  logic [4:0]  bit_cnt;
  logic        accept;
  logic        shift_en;

  assign accept   = (state == IDLE) && bus.req_valid;
  // A bit is only consumed on cycles where it was actually presented with grant.
  assign shift_en = ((state == ADDR) || (state == DATA)) && bus.bus_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = REQ;
      REQ:  if (bus.bus_grant) state_nxt = ADDR;
      ADDR: if (bus.bus_grant && (bit_cnt == 5'd15)) state_nxt = DATA;
      DATA: if (bus.bus_grant && (bit_cnt == 5'd7))  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready          = 1'b0;
    bus.bus_req            = 1'b0;
    bus.bus_data_out       = 1'b0;
    bus.bus_data_out_valid = 1'b0;
    bus.bus_mode           = 1'b0;
    bus.busy               = 1'b1;
    bus.done               = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      REQ: begin
        bus.bus_req = 1'b1;
      end
      ADDR: begin
        bus.bus_req            = 1'b1;
        bus.bus_data_out       = addr_sr[0];
        bus.bus_data_out_valid = bus.bus_grant;
      end
      DATA: begin
        bus.bus_req            = 1'b1;
        bus.bus_data_out       = data_sr[0];
        bus.bus_data_out_valid = bus.bus_grant;
        bus.bus_mode           = 1'b1;
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sr <= 16'd0;
      data_sr <= 8'd0;
      bit_cnt <= 5'd0;
    end else if (accept) begin
      addr_sr <= bus.req_addr;
      data_sr <= bus.req_wdata;
      bit_cnt <= 5'd0;
    end else if (shift_en) begin
      if (state == ADDR) begin
        addr_sr <= {1'b0, addr_sr[15:1]};
        bit_cnt <= (bit_cnt == 5'd15) ? 5'd0 : bit_cnt + 5'd1;
      end else begin
        data_sr <= {1'b0, data_sr[7:1]};
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

endmodule

// File: doc/bus_master_serializer.md
BUS_MASTER_SERIALIZER -- requirements
Module: bus_master_serializer

Interface
REQ-001 The block SHALL use clock clk and reset rst_n, asynchronous, active-low; all flops SHALL be clocked on posedge clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  write request present.
REQ-005 req_ready  output  1  block idle and able to accept a request.
REQ-006 req_addr  input  16  target address, sampled on acceptance.
REQ-007 req_wdata  input  8  write data, sampled on acceptance.
REQ-008 bus_req  output  1  bus request to arbiter.
REQ-009 bus_grant  input  1  bus grant from arbiter, level-sensitive.
REQ-010 bus_data_out  output  1  serial bit to address decoder and targets.
REQ-011 bus_data_out_valid  output  1  bus_data_out carries a valid bit this cycle.
REQ-012 bus_mode  output  1  1 = data phase, 0 = address phase.
REQ-013 busy  output  1  transfer in progress (any state except IDLE).
REQ-014 done  output  1  one-cycle pulse on frame completion.

Function
REQ-015 FSM states SHALL be IDLE, REQ, ADDR, DATA, DONE, held in a registered state variable.
REQ-016 req_ready SHALL be 1 only in IDLE; acceptance = req_valid && req_ready at a clock edge.
REQ-017 On acceptance: req_addr -> 16-bit addr shift reg, req_wdata -> 8-bit data shift reg, bit counter cleared, state -> REQ; req_addr/req_wdata ignored at all other times.
REQ-018 bus_req SHALL be 1 in REQ, ADDR and DATA; 0 in IDLE and DONE.
REQ-019 REQ: stay while bus_grant=0; on edge with bus_grant=1 -> ADDR.
REQ-020 bus_data_out_valid SHALL be combinational: (state==ADDR || state==DATA) && bus_grant.
REQ-021 bus_data_out SHALL equal bit 0 of active shift reg (addr in ADDR, data in DATA); 0 in IDLE/REQ/DONE.
REQ-022 bus_mode SHALL be 1 exactly in DATA; 0 in every other state, incl. stalls within ADDR.
REQ-023 Serialization SHALL be LSB first: addr[0] first valid ADDR bit, addr[15] 16th; wdata[0] first DATA bit, wdata[7] 8th.
REQ-024 Shift reg and 5-bit bit counter SHALL advance only on edges where bus_data_out_valid=1.
REQ-025 ADDR: after 16th valid bit (counter==15) -> DATA, counter cleared to 0.
REQ-026 DATA: after 8th valid bit (counter==7) -> DONE.
REQ-027 DONE SHALL last exactly one cycle with done=1, then -> IDLE.
REQ-028 Grant drop in ADDR/DATA SHALL stall: valid=0, bit/mode/counter held, bus_req held 1; resume on same bit when grant returns.
REQ-029 bus_grant in IDLE or DONE SHALL be ignored.
REQ-030 Minimum latency with bus_grant tied 1: acceptance edge T0, REQ in cycle 1, address bits cycles 2-17, data bits cycles 18-25, done cycle 26, req_ready=1 cycle 27.
REQ-031 Back-to-back: new request accepted in first IDLE cycle after DONE; no overlap of frames.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force state IDLE, shift regs and counter 0, req_ready=1, bus_req=0, bus_data_out=0, bus_data_out_valid=0, bus_mode=0, busy=0, done=0.
REQ-033 Reset mid-frame SHALL abandon the frame without completing or pulsing done; no request SHALL be accepted while rst_n=0.

Verification
REQ-034 Grant tied 1, addr=0x0123, wdata=0xA5 -> valid bits cycles 2-25, mode 0 sequence 1,1,0,0,0,1,0,0,1,0,0,0,0,0,0,0, then mode 1 sequence 1,0,1,0,0,1,0,1, done at cycle 26.
REQ-035 Grant withheld 5 cycles after acceptance -> bus_req=1, valid=0 for 5 cycles, then REQ-034 timing shifted by 5.
REQ-036 Grant dropped 3 cycles after 10th address bit -> valid=0, mode=0, bit 10 held 3 cycles; frame completes with 24 valid bits total, decoder selects correct target (addr 0x4000 -> target_2_valid=1, sel=01).
REQ-037 req_valid held 1 with changing addr during a transfer -> only first request serialized; second accepted cycle after done.
REQ-038 rst_n asserted at 5th data bit -> all outputs at reset values same cycle, no done pulse; after release, new request 0x8001/0x3C completes normally.
